dds_keypad_ctrl: RTL and testbench
==================================

Name: dds_keypad_ctrl

Overview:
Command controller between the 4x4 matrix keypad scanner and the DDS configuration registers. It consumes scanner key codes and keypress pulses and builds a decimal entry buffer. It converts the buffer to binary with a sequential multiply-add FSM, range-checks the result and issues frequency, phase or waveform updates over a valid/ready configuration handshake. Single clock domain. Sits between the keypad scanner and the DDS register bank.

Parameters:
MAX_DIGITS, 7, decimal digits accepted in frequency mode (phase mode always 3)
FREQ_MAX, 5000000, largest legal frequency value
PHASE_MAX, 359, largest legal phase value in degrees
DATA_W, 32, width of cfg_data

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
key  input  5  scanner key code; 0-15 valid, 16 = no key
keypress  input  1  one-cycle pulse marking a new key value
cfg_data  output  DATA_W  value being issued
cfg_sel  output  2  target: 0 frequency, 1 phase, 2 waveform
cfg_valid  output  1  cfg_data/cfg_sel valid
cfg_ready  input  1  DDS register bank accepts the transfer
mode  output  1  entry mode: 0 frequency, 1 phase
digit_cnt  output  4  digits currently in the buffer
disp_bcd  output  4*MAX_DIGITS  BCD buffer, least significant digit in [3:0]
wave_sel  output  2  current waveform index
busy  output  1  high in every state except ENTRY
err  output  1  one-cycle pulse on a range violation

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to ENTRY.
  - All outputs go to 0, including mode, wave_sel, buffer and digit_cnt.
  - Reset overrides any state, including ISSUE with cfg_valid high. The transfer is abandoned.
- A key is accepted only when keypress==1, key<=15 and the state is ENTRY. All other keypresses are dropped.
- Key map in ENTRY:
  - 0-9: digit. If digit_cnt < limit (MAX_DIGITS in frequency mode, 3 in phase mode), shift the buffer left by one digit, insert the new digit at [3:0] and increment digit_cnt. At the limit, ignore the key.
  - 10: set mode=0, clear buffer and digit_cnt.
  - 11: set mode=1, clear buffer and digit_cnt.
  - 12: clear buffer and digit_cnt.
  - 13: backspace. If digit_cnt>0, shift the buffer right by one digit, zero-fill the top digit and decrement digit_cnt.
  - 14: wave_sel <= wave_sel+1 (mod 4, 3 wraps to 0). Load cfg_data with the new index zero-extended, set cfg_sel=2, go to ISSUE. Buffer is untouched.
  - 15: enter. If digit_cnt==0, ignore. Otherwise clear acc, load idx=digit_cnt-1 and go to CONVERT.
- CONVERT: one digit per cycle, most significant digit first.
  - acc <= (acc<<3) + (acc<<1) + bcd[idx]. The adder is DATA_W+4 bits wide, so there is no overflow.
  - When idx==0, go to CHECK. Otherwise decrement idx.
  - Takes exactly digit_cnt cycles.
- CHECK: one cycle. limit = mode ? PHASE_MAX : FREQ_MAX.
  - If acc > limit: pulse err for this cycle, keep the buffer, return to ENTRY.
  - Otherwise: cfg_data <= acc[DATA_W-1:0], cfg_sel <= {1'b0, mode}, go to ISSUE.
- ISSUE: cfg_valid=1, with cfg_data and cfg_sel held stable.
  - A transfer happens on a clk edge where cfg_valid and cfg_ready are both 1.
  - The next cycle, cfg_valid=0 and the FSM is in ENTRY.
  - For cfg_sel 0 or 1, the buffer and digit_cnt clear on transfer. For cfg_sel=2, the buffer is untouched.
  - cfg_ready may stay low indefinitely. No timeout.
- Latency, with the enter keypress sampled at edge T:
  - CONVERT occupies cycles T+1..T+n.
  - CHECK occupies T+n+1.
  - cfg_valid first goes high at T+n+2, where n = digit_cnt.
- Wave key sampled at edge T: cfg_valid goes high at T+1.
- cfg_ready while cfg_valid==0 has no effect.
- cfg_data and cfg_sel hold their last issued values after a transfer.

Test Plan:
- Reset, then keys 1,2,3,4,15 with cfg_ready=1 -> disp_bcd[15:0]=0x1234 before enter. cfg_valid pulses 6 cycles after the enter pulse with cfg_data=1234, cfg_sel=0. digit_cnt=0 after transfer.
- Keys 11,3,6,0,15 -> err pulses once, no cfg_valid, disp_bcd[11:0]=0x360. Then keys 13,13,9,15 -> issue cfg_data=39, cfg_sel=1.
- Keys 9 pressed 8 times in frequency mode -> digit_cnt stops at 7. Enter gives 9999999 > 5000000 -> err pulses and the buffer is retained.
- Key 14 pressed five times, each accepted -> wave_sel sequence 1,2,3,0,1. Each press issues cfg_sel=2 with cfg_data equal to the new index.
- Enter "50" with cfg_ready=0 for 10 cycles -> cfg_valid held with cfg_data=50 and digit keys ignored during the wait. Raising cfg_ready completes one transfer.
- Drive reset=0 while in ISSUE -> at the next edge cfg_valid=0, state ENTRY, mode=0, wave_sel=0. keypress with key=16, or with no reset release, causes no change.

Source files
------------

// File: rtl/dds_keypad_ctrl_if.sv
// Configuration bus between the keypad controller and the DDS register bank.
//   cfg_data  : value being issued
//   cfg_sel   : target, 0 frequency, 1 phase, 2 waveform
//   cfg_valid : cfg_data/cfg_sel valid
//   cfg_ready : register bank accepts the transfer
// A transfer completes on a clk edge where cfg_valid and cfg_ready are both high.
interface dds_keypad_ctrl_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] cfg_data;
  logic [1:0]        cfg_sel;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_data, output cfg_sel, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_sel, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/dds_keypad_ctrl.sv
// Keypad command controller for the DDS.
// Builds a decimal entry buffer from scanner key codes, converts it to binary
// one digit per cycle (MSD first), range-checks it and issues frequency/phase/
// waveform updates on the cfg valid/ready bus.
//   clk, reset  : clock, synchronous active-low reset
//   key         : scanner code, 0-15 valid, 16 = no key
//   keypress    : one-cycle strobe for a new key
//   cfg         : configuration bus (master side)
//   mode        : 0 frequency entry, 1 phase entry
//   digit_cnt   : digits in the buffer
//   disp_bcd    : BCD buffer, least significant digit in [3:0]
//   wave_sel    : current waveform index
//   busy        : high outside ENTRY
//   err         : one-cycle pulse on range violation
module dds_keypad_ctrl #(
  parameter int MAX_DIGITS = 7,
  parameter int FREQ_MAX   = 5000000,
  parameter int PHASE_MAX  = 359,
  parameter int DATA_W     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4:0]                key,
  input  logic                      keypress,
  dds_keypad_ctrl_if.master         cfg,
  output logic                      mode,
  output logic [3:0]                digit_cnt,
  output logic [4*MAX_DIGITS-1:0]   disp_bcd,
  output logic [1:0]                wave_sel,
  output logic                      busy,
  output logic                      err
);
  localparam int AW    = DATA_W + 4;
  localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

  typedef enum logic [1:0] {ENTRY, CONVERT, CHECK, ISSUE} state_t;

  state_t                     state_q, state_d;
  logic [MAX_DIGITS-1:0][3:0] bcd_q;
  logic [3:0]                 cnt_q;
  logic                       mode_q;
  logic [1:0]                 wave_q;
  logic [AW-1:0]              acc_q;
  logic [IDX_W-1:0]           idx_q;
  logic [DATA_W-1:0]          data_q;
  logic [1:0]                 sel_q;

  logic          key_ok, xfer, over;
  logic [3:0]    cnt_lim;
  logic [AW-1:0] limit, acc_nx;
  logic [1:0]    wave_nx;

  assign key_ok  = keypress && (key <= 5'd15) && (state_q == ENTRY);
  assign xfer    = (state_q == ISSUE) && cfg.cfg_ready;
  assign cnt_lim = mode_q ? 4'd3 : 4'(MAX_DIGITS);
  assign limit   = mode_q ? AW'(PHASE_MAX) : AW'(FREQ_MAX);
  assign over    = acc_q > limit;
  // acc*10 + digit; AW leaves headroom so the multiply-add cannot wrap
  assign acc_nx  = (acc_q << 3) + (acc_q << 1) + AW'(bcd_q[idx_q]);
  assign wave_nx = wave_q + 2'd1;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ENTRY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ENTRY: begin
        if (key_ok && key[3:0] == 4'd14)                     state_d = ISSUE;
        else if (key_ok && key[3:0] == 4'd15 && cnt_q != 0)  state_d = CONVERT;
      end
      CONVERT: if (idx_q == '0) state_d = CHECK;
      CHECK:   state_d = over ? ENTRY : ISSUE;
      ISSUE:   if (cfg.cfg_ready) state_d = ENTRY;
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bcd_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      wave_q <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
      sel_q  <= '0;
    end else begin
      case (state_q)
        ENTRY: if (key_ok) begin
          if (key < 5'd10) begin
            if (cnt_q < cnt_lim) begin
              bcd_q <= {bcd_q[MAX_DIGITS-2:0], key[3:0]};
              cnt_q <= cnt_q + 4'd1;
            end
          end else begin
            case (key[3:0])
              4'd10: begin mode_q <= 1'b0; bcd_q <= '0; cnt_q <= '0; end
              4'd11: begin mode_q <= 1'b1; bcd_q <= '0; cnt_q <= '0; end
              4'd12: begin bcd_q <= '0; cnt_q <= '0; end
              4'd13: if (cnt_q != 0) begin
                bcd_q <= {4'h0, bcd_q[MAX_DIGITS-1:1]};
                cnt_q <= cnt_q - 4'd1;
              end
              4'd14: begin
                wave_q <= wave_nx;
                data_q <= {{(DATA_W-2){1'b0}}, wave_nx};
                sel_q  <= 2'd2;
              end
              default: if (cnt_q != 0) begin
                acc_q <= '0;
                idx_q <= IDX_W'(cnt_q - 4'd1);
              end
            endcase
          end
        end
        CONVERT: begin
          acc_q <= acc_nx;
          if (idx_q != '0) idx_q <= idx_q - 1'b1;
        end
        CHECK: if (!over) begin
          data_q <= acc_q[DATA_W-1:0];
          sel_q  <= {1'b0, mode_q};
        end
        ISSUE: if (xfer && sel_q != 2'd2) begin
          bcd_q <= '0;
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign cfg.cfg_data  = data_q;
  assign cfg.cfg_sel   = sel_q;
  assign cfg.cfg_valid = (state_q == ISSUE);
  assign mode          = mode_q;
  assign digit_cnt     = cnt_q;
  assign disp_bcd      = bcd_q;
  assign wave_sel      = wave_q;
  assign busy          = (state_q != ENTRY);
  assign err           = (state_q == CHECK) && over;
endmodule

// File: tb/tb_dds_keypad_ctrl.sv
module tb_dds_keypad_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  key;
  logic        keypress;
  logic        mode;
  logic [3:0]  digit_cnt;
  logic [27:0] disp_bcd;
  logic [1:0]  wave_sel;
  logic        busy;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  dds_keypad_ctrl_if #(.DATA_W(32)) cfg_if ();

  dds_keypad_ctrl #(.MAX_DIGITS(7), .FREQ_MAX(5000000), .PHASE_MAX(359), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .key(key), .keypress(keypress), .cfg(cfg_if.master),
    .mode(mode), .digit_cnt(digit_cnt), .disp_bcd(disp_bcd), .wave_sel(wave_sel),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  key;
    logic [3:0]  cnt;
    logic [27:0] bcd;
    logic        mode;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one keypress strobe; returns at the negedge after the sampling edge
  task automatic press(input logic [4:0] k);
    @(negedge clk);
    key = k;
    keypress = 1'b1;
    @(negedge clk);
    keypress = 1'b0;
    key = 5'd16;
  endtask

  // cycle index (1 = cycle right after enter edge) where cfg_valid first seen
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!cfg_if.cfg_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic count_events(input int n, output int errs, output int vals);
    errs = 0;
    vals = 0;
    for (int i = 0; i < n; i++) begin
      if (err) errs++;
      if (cfg_if.cfg_valid) vals++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc, ne, nv;
    tbl[0]  = '{5'd1,  4'd1, 28'h1,    1'b0};
    tbl[1]  = '{5'd2,  4'd2, 28'h12,   1'b0};
    tbl[2]  = '{5'd3,  4'd3, 28'h123,  1'b0};
    tbl[3]  = '{5'd4,  4'd4, 28'h1234, 1'b0};
    tbl[4]  = '{5'd13, 4'd3, 28'h123,  1'b0};
    tbl[5]  = '{5'd16, 4'd3, 28'h123,  1'b0};
    tbl[6]  = '{5'd11, 4'd0, 28'h0,    1'b1};
    tbl[7]  = '{5'd5,  4'd1, 28'h5,    1'b1};
    tbl[8]  = '{5'd6,  4'd2, 28'h56,   1'b1};
    tbl[9]  = '{5'd7,  4'd3, 28'h567,  1'b1};
    tbl[10] = '{5'd8,  4'd3, 28'h567,  1'b1};
    tbl[11] = '{5'd13, 4'd2, 28'h56,   1'b1};
    tbl[12] = '{5'd12, 4'd0, 28'h0,    1'b1};
    tbl[13] = '{5'd10, 4'd0, 28'h0,    1'b0};
    tbl[14] = '{5'd9,  4'd1, 28'h9,    1'b0};
    tbl[15] = '{5'd12, 4'd0, 28'h0,    1'b0};

    reset = 1'b0;
    key = 5'd16;
    keypress = 1'b0;
    cfg_if.cfg_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", cfg_if.cfg_valid, 0);
    chk("rst_data",  cfg_if.cfg_data, 0);
    chk("rst_sel",   cfg_if.cfg_sel, 0);
    chk("rst_mode",  mode, 0);
    chk("rst_cnt",   digit_cnt, 0);
    chk("rst_bcd",   disp_bcd, 0);
    chk("rst_wave",  wave_sel, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_err",   err, 0);
    reset = 1'b1;

    // buffer editing table
    for (int i = 0; i < 16; i++) begin
      press(tbl[i].key);
      chk($sformatf("tbl%0d_cnt", i),  digit_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_bcd", i),  disp_bcd,  tbl[i].bcd);
      chk($sformatf("tbl%0d_mode", i), mode,      tbl[i].mode);
    end

    // frequency 1234, latency n+2
    press(1); press(2); press(3); press(4);
    chk("f1234_bcd", disp_bcd[15:0], 16'h1234);
    press(15);
    chk("f1234_busy", busy, 1);
    wait_valid(cyc);
    chk("f1234_lat",  cyc, 6);
    chk("f1234_data", cfg_if.cfg_data, 1234);
    chk("f1234_sel",  cfg_if.cfg_sel, 0);
    @(negedge clk);
    chk("f1234_vdone", cfg_if.cfg_valid, 0);
    chk("f1234_cnt",   digit_cnt, 0);
    chk("f1234_busy0", busy, 0);

    // phase 360 out of range, then 39
    press(11); press(3); press(6); press(0); press(15);
    count_events(12, ne, nv);
    chk("p360_err",   ne, 1);
    chk("p360_valid", nv, 0);
    chk("p360_bcd",   disp_bcd[11:0], 12'h360);
    chk("p360_cnt",   digit_cnt, 3);
    press(13); press(13); press(9);
    chk("p39_bcd", disp_bcd[11:0], 12'h039);
    press(15);
    wait_valid(cyc);
    chk("p39_lat",  cyc, 4);
    chk("p39_data", cfg_if.cfg_data, 39);
    chk("p39_sel",  cfg_if.cfg_sel, 1);
    @(negedge clk);
    chk("p39_cnt", digit_cnt, 0);

    // digit limit and frequency overflow
    press(10);
    for (int i = 0; i < 8; i++) press(9);
    chk("lim_cnt", digit_cnt, 7);
    chk("lim_bcd", disp_bcd, 28'h9999999);
    press(15);
    count_events(14, ne, nv);
    chk("fovr_err",   ne, 1);
    chk("fovr_valid", nv, 0);
    chk("fovr_bcd",   disp_bcd, 28'h9999999);
    chk("fovr_cnt",   digit_cnt, 7);

    // waveform cycling, buffer untouched
    for (int i = 0; i < 5; i++) begin
      logic [1:0] w;
      w = 2'((i + 1) % 4);
      press(14);
      chk($sformatf("wave%0d_valid", i), cfg_if.cfg_valid, 1);
      chk($sformatf("wave%0d_sel", i),   cfg_if.cfg_sel, 2);
      chk($sformatf("wave%0d_data", i),  cfg_if.cfg_data, w);
      chk($sformatf("wave%0d_idx", i),   wave_sel, w);
    end
    @(negedge clk);
    chk("wave_vdone", cfg_if.cfg_valid, 0);
    chk("wave_cnt",   digit_cnt, 7);

    // backpressure: 50 held while ready low
    press(12); press(5); press(0);
    cfg_if.cfg_ready = 1'b0;
    press(15);
    wait_valid(cyc);
    chk("bp_lat", cyc, 4);
    press(7); press(7);
    repeat (6) @(negedge clk);
    chk("bp_valid", cfg_if.cfg_valid, 1);
    chk("bp_data",  cfg_if.cfg_data, 50);
    chk("bp_sel",   cfg_if.cfg_sel, 0);
    chk("bp_bcd",   disp_bcd, 28'h50);
    chk("bp_cnt",   digit_cnt, 2);
    cfg_if.cfg_ready = 1'b1;
    @(negedge clk);
    count_events(4, ne, nv);
    chk("bp_onexfer", nv, 0);
    chk("bp_cnt0",    digit_cnt, 0);
    chk("bp_hold",    cfg_if.cfg_data, 50);

    // reset during ISSUE
    press(11);
    cfg_if.cfg_ready = 1'b0;
    press(14);
    chk("ri_valid_pre", cfg_if.cfg_valid, 1);
    chk("ri_wave_pre",  wave_sel, 2);
    reset = 1'b0;
    @(negedge clk);
    chk("ri_valid", cfg_if.cfg_valid, 0);
    chk("ri_busy",  busy, 0);
    chk("ri_mode",  mode, 0);
    chk("ri_wave",  wave_sel, 0);
    chk("ri_data",  cfg_if.cfg_data, 0);
    press(5);
    chk("ri_held_cnt", digit_cnt, 0);
    reset = 1'b1;
    cfg_if.cfg_ready = 1'b1;
    press(16);
    chk("ri_nokey_cnt", digit_cnt, 0);
    chk("ri_nokey_bcd", disp_bcd, 0);
    press(5);
    chk("ri_after_cnt", digit_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
